// File: rtl/psum_collector.sv
// Output-side buffer for the systolic array: one FIFO per column, filled by skewed
// per-column strobes and drained one aligned full-width row at a time.
module psum_collector #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         valid,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   out_strobe,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   ready,
    output logic [col-1:0]         overflow
);

    localparam int aw = $clog2(depth);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [aw:0]          wptr [col];
    logic [aw:0]          rptr [col];
    logic [psum_bw-1:0]   mem  [col][depth];

    logic [col-1:0]         full;
    logic [col-1:0]         nonempty;
    logic [col-1:0]         wr_en;
    logic                   pop;
    logic [psum_bw*col-1:0] rd_row;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        full     = '0;
        nonempty = '0;
        rd_row   = '0;
        for (int c = 0; c < col; c++) begin
            full[c]     = (wptr[c][aw-1:0] == rptr[c][aw-1:0]) && (wptr[c][aw] != rptr[c][aw]);
            nonempty[c] = (wptr[c] != rptr[c]);
            rd_row[psum_bw*c +: psum_bw] = mem[c][rptr[c][aw-1:0]];
        end
    end

    // Fullness is judged before the edge, so a same-cycle pop never rescues a write.
    assign wr_en   = valid & ~full;
    assign o_valid = &nonempty;
    assign o_full  = |full;
    assign ready   = ~o_full;
    assign pop     = rd & o_valid;

    // NOTE: state registers use non-blocking assignments so all columns update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < col; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            overflow   <= '0;
            out        <= '0;
            out_strobe <= 1'b0;
        end else begin
            for (int c = 0; c < col; c++) begin
                if (wr_en[c]) wptr[c] <= wptr[c] + 1'b1;
                if (pop)      rptr[c] <= rptr[c] + 1'b1;
            end
            overflow   <= overflow | (valid & full);
            out_strobe <= pop;
            if (pop) out <= rd_row;
        end
    end

    // NOTE: storage is not reset; clearing the pointers already discards its contents.
    always_ff @(posedge clk) begin
        for (int c = 0; c < col; c++) begin
            if (wr_en[c]) mem[c][wptr[c][aw-1:0]] <= in[psum_bw*c +: psum_bw];
        end
    end

endmodule

// File: doc/psum_collector.md
# psum_collector

Output-side buffer for the systolic array. It captures the per-column partial sums leaving the bottom MAC row, using that row's per-column `valid` strobes. Columns are written independently, because valids arrive skewed by one cycle per column. A reader pops one aligned full-width row (all columns) at a time. The block sits between the last MAC row's `out_s`/`valid` and the SFU/writeback path.

## Interface
- `col`, 8, number of array columns
- `psum_bw`, 16, bits per column partial sum
- `depth`, 64, entries per column FIFO; must be a power of 2, ≥2

- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `in`  in  psum_bw*col  column psums; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c]
- `valid`  in  col  per-column write strobe; bit c qualifies column c of `in`
- `rd`  in  1  pop request for one full row
- `out`  out  psum_bw*col  popped row, same column packing as `in`
- `out_strobe`  out  1  high for one cycle when `out` holds a newly popped row
- `o_valid`  out  1  every column FIFO is non-empty
- `o_full`  out  1  at least one column FIFO is full
- `ready`  out  1  no column FIFO is full (equals `~o_full`)
- `overflow`  out  col  sticky flag; bit c set when a write to full column c was dropped

## Operation
- There is one FIFO per column. Each FIFO has:
  - a write pointer and a read pointer, each log2(depth)+1 bits; the MSB is the wrap bit;
  - count = wptr − rptr (mod 2·depth), in the range 0..depth.
- Write, column c, each cycle:
  - `valid[c]`=1 and count_c < depth: store `in[c]` at wptr_c, then wptr_c+1.
  - `valid[c]`=1 and count_c == depth: drop the data, leave wptr_c unchanged, set `overflow[c]`=1.
  - Fullness is judged on the pre-edge count. A write to a full column is dropped even if a pop occurs in the same cycle.
- Read:
  - `rd`=1 and `o_valid`=1: every column's entry at rptr_c is registered into `out`, every rptr_c+1, and `out_strobe`=1 in the next cycle.
  - `rd`=1 and `o_valid`=0: ignored. No pointer moves, `out` holds, `out_strobe`=0.
  - Pops are always all-column; partial pops do not exist.
- Simultaneous write and pop on the same non-full column: both happen and count is unchanged. On an empty column, the pop is impossible because `o_valid`=0.
- Pointer wrap: depth−1 → 0 in the address bits, with the wrap bit toggled. Full is detected as equal address bits with different wrap bits.
- Status outputs are combinational from the current counts:
  - `o_valid` = AND over columns of (count_c>0);
  - `o_full` = OR over columns of (count_c==depth).
- No arithmetic is performed on data; psums are stored bit-exact.
- `overflow` bits clear only on reset.

## Timing
- Reset values (`reset`=0, asynchronous): all pointers 0, `out`=0, `out_strobe`=0, `overflow`=0. As a result `o_valid`=0, `o_full`=0, `ready`=1.
- Reset mid-operation: all stored contents are discarded immediately. Memory contents need not be cleared.
- Write latency: data written at edge t is visible to a pop request presented in cycle t+1. `o_valid` reflects the write in cycle t+1.
- Read latency: with `rd` and `o_valid` high in cycle t, `out`/`out_strobe` are valid in cycle t+1. Back-to-back pops sustain one row per cycle.
- `out` holds its last popped value while `out_strobe`=0.
- Column skew: column c may lag column 0 by any number of cycles. A row becomes poppable only once its last column has been written.

## Test plan
- Reset then idle: `reset` low for 2 cycles → `out`=0, `out_strobe`=0, `ready`=1, `o_valid`=0, `overflow`=0.
- Skewed fill: column c gets value 16'h0100+c with `valid[c]` at cycle c, for c=0..7.
  - `o_valid` rises only in cycle 8.
  - `rd` in cycle 8 → in cycle 9, `out` column c = 16'h0100+c and `out_strobe`=1.
  - `o_valid` then returns to 0.
- Full and overflow (depth=4): write 4 rows to all columns → `o_full`=1, `ready`=0.
  - A 5th write to column 3 only sets `overflow`=8'h08.
  - Popping 4 rows returns rows 0..3 in order, with no trace of the dropped value.
- Pointer wrap (depth=4): interleave 10 writes and 10 pops of row values 0..9 → pops return 0..9 in order; `o_full` is never set.
- Empty read: `rd`=1 with one column empty → no `out_strobe`, `out` unchanged, and the other columns' counts are unchanged.
- Simultaneous write/pop with count 2 everywhere: `valid`=8'hFF and `rd`=1 in the same cycle → the oldest row is output, counts stay 2, and the new row is popped two pops later.
